// File: rtl/instr_sequencer_if.sv
// Instruction handshake bundle between the issuing upstream and instr_sequencer.
// A word transfers on a rising edge where instr_valid && instr_ready; the upstream holds instr stable until then.
interface instr_sequencer_if #(
   parameter int INSTR_W = 10
) ();
   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr;

   modport master (output instr_valid, output instr, input instr_ready);
   modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: feeds {func, rx, ry} and the registered state to the control FSM, flags retire (done) or failure (err).
// Build option SEQ_PREFETCH_EN adds a one-entry prefetch buffer so back-to-back instructions issue without a bubble.
module instr_sequencer #(
   parameter int MAX_STEPS = 7,
   parameter int INSTR_W   = 10
) (
   input  logic             clk,
   input  logic             resetn,
   instr_sequencer_if.slave bus,
   output logic [3:0]       func,
   output logic [2:0]       input1,
   output logic [2:0]       input2,
   output logic [4:0]       current_state,
   input  logic [4:0]       next_state,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             seq_state
);
   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_RUN    = 1'b1;
   localparam logic [2:0] STEP_MAX = 3'(MAX_STEPS);

   logic [0:0]         state;
   logic [2:0]         step;
   logic [4:0]         term;
   logic               finish;
   logic               fail;
   logic               exit_run;
   logic               accept;
   logic               load_en;
   logic [INSTR_W-1:0] load_word;

   assign seq_state = state[0];

   // Terminal FSM state per opcode; 0 marks an opcode with no legal sequence.
   always_comb begin
      term = 5'b00000;
      case (func)
         4'b0001: term = 5'b00001;
         4'b0010: term = 5'b00010;
         4'b0011: term = 5'b00101;
         4'b0100: term = 5'b01001;
         4'b0101: term = 5'b01100;
         4'b0110: term = 5'b01111;
         4'b0111: term = 5'b10010;
         4'b1000: term = 5'b10101;
         4'b1001: term = 5'b11000;
         default: term = 5'b00000;
      endcase
   end

   // Completion wins over the watchdog when both land on the same step.
   assign finish   = (state == S_RUN) && (term != 5'd0) && (next_state == term);
   assign fail     = (state == S_RUN) && !finish && ((next_state == 5'd0) || (step == STEP_MAX));
   assign exit_run = finish || fail;
   assign accept   = bus.instr_valid && bus.instr_ready;

`ifdef SEQ_PREFETCH_EN
   logic               buf_valid;
   logic [INSTR_W-1:0] buf_word;

   assign bus.instr_ready = !buf_valid;
   // A buffered word starts as soon as the sequencer is free: from IDLE or on the retiring edge.
   assign load_en   = (accept && (state == S_IDLE)) || (buf_valid && ((state == S_IDLE) || exit_run));
   assign load_word = buf_valid ? buf_word : bus.instr;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         buf_valid <= 1'b0;
         buf_word  <= '0;
      end else if (accept && (state == S_RUN)) begin
         buf_valid <= 1'b1;
         buf_word  <= bus.instr;
      end else if (buf_valid && ((state == S_IDLE) || exit_run)) begin
         buf_valid <= 1'b0;
      end
   end
`else
   // The done/err cycle is left idle so a new word never overlaps the retire pulse.
   assign bus.instr_ready = (state == S_IDLE) && !done && !err;
   assign load_en         = accept;
   assign load_word       = bus.instr;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= S_IDLE;
         func          <= 4'd0;
         input1        <= 3'd0;
         input2        <= 3'd0;
         current_state <= 5'd0;
         step          <= 3'd0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         done <= finish;
         err  <= fail;
         if (load_en) begin
            state         <= S_RUN;
            func          <= load_word[INSTR_W-1 -: 4];
            input1        <= load_word[5:3];
            input2        <= load_word[2:0];
            current_state <= 5'd0;
            step          <= 3'd0;
            busy          <= 1'b1;
         end else if (exit_run) begin
            // The terminal state is never presented to the FSM.
            state         <= S_IDLE;
            func          <= 4'd0;
            current_state <= 5'd0;
            step          <= 3'd0;
            busy          <= 1'b0;
         end else if (state == S_RUN) begin
            current_state <= next_state;
            if (step != STEP_MAX) step <= step + 3'd1;
         end
      end
   end
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: table vectors, hand-written corner sequences and randomized instructions
// checked against an outcome model (legal/illegal, latency, operand fields) through an expected queue.
module tb_instr_sequencer;
   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic [3:0] func;
   logic [2:0] input1, input2;
   logic [4:0] current_state, next_state;
   logic       busy, done, err, seq_state;
   logic       stub_loop = 1'b0;
   int         checks = 0;
   int         errors = 0;
   logic [10:0] exp_q[$];

   always #5 clk = ~clk;

   instr_sequencer_if bus ();

   instr_sequencer dut (
      .clk(clk), .resetn(resetn), .bus(bus),
      .func(func), .input1(input1), .input2(input2),
      .current_state(current_state), .next_state(next_state),
      .busy(busy), .done(done), .err(err), .seq_state(seq_state)
   );

   function automatic logic [4:0] term_of(input logic [3:0] f);
      logic [4:0] t [16] = '{5'd0, 5'd1, 5'd2, 5'd5, 5'd9, 5'd12, 5'd15, 5'd18,
                             5'd21, 5'd24, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
      return t[f];
   endfunction

   // Stand-in control FSM: load/move finish in one step, ALU ops walk 0 -> 3 -> 4 -> terminal.
   always_comb begin
      next_state = 5'd0;
      if (stub_loop) next_state = 5'b00011;
      else if (func == 4'd1 || func == 4'd2) next_state = (current_state == 5'd0) ? term_of(func) : 5'd0;
      else if (func >= 4'd3 && func <= 4'd9) begin
         case (current_state)
            5'd0:    next_state = 5'd3;
            5'd3:    next_state = 5'd4;
            5'd4:    next_state = term_of(func);
            default: next_state = 5'd0;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic send(input logic [9:0] w);
      bus.instr = w;
      bus.instr_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (bus.instr_ready) begin
            tick();
            bus.instr_valid = 1'b0;
            return;
         end
         tick();
      end
      bus.instr_valid = 1'b0;
      checks++;
      errors++;
      $display("FAIL timeout_ready actual=no_accept expected=accept within 20 cycles");
   endtask

   task automatic wait_end(output int n, output logic stable);
      logic [2:0] a, b;
      a = input1;
      b = input2;
      stable = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         n++;
         if (input1 !== a || input2 !== b) stable = 1'b0;
         if (done || err) return;
      end
      checks++;
      errors++;
      $display("FAIL timeout_end actual=%0d cycles expected=done or err", n);
   endtask

   typedef struct {
      logic [9:0] instr;
      logic       ok;
      int         lat;
   } vec_t;

   initial begin
      vec_t vt [12];
      int   n;
      logic st;

      bus.instr_valid = 1'b0;
      bus.instr = '0;

      // Reset values, applied asynchronously between edges.
      #2 resetn = 1'b0;
      #1;
      chk("rst_func", func, 0);
      chk("rst_cs", current_state, 0);
      chk("rst_flags", {busy, done, err, input1, input2}, 0);
      repeat (2) tick();
      resetn = 1'b1;
      tick();
      chk("rst_ready", bus.instr_ready, 1);

      vt[0]  = '{10'b0001_010_000, 1'b1, 1};
      vt[1]  = '{10'b0010_111_001, 1'b1, 1};
      vt[2]  = '{10'b0011_001_010, 1'b1, 3};
      vt[3]  = '{10'b0100_011_100, 1'b1, 3};
      vt[4]  = '{10'b0101_101_110, 1'b1, 3};
      vt[5]  = '{10'b0110_000_111, 1'b1, 3};
      vt[6]  = '{10'b0111_110_001, 1'b1, 3};
      vt[7]  = '{10'b1000_100_100, 1'b1, 3};
      vt[8]  = '{10'b1001_111_111, 1'b1, 3};
      vt[9]  = '{10'b0000_001_001, 1'b0, 1};
      vt[10] = '{10'b1010_010_011, 1'b0, 1};
      vt[11] = '{10'b1111_000_000, 1'b0, 1};

      foreach (vt[i]) begin
         send(vt[i].instr);
         chk("acc_func", func, 32'(vt[i].instr[9:6]));
         chk("acc_ops", {input1, input2}, 32'(vt[i].instr[5:0]));
         chk("acc_cs_busy", {current_state, busy}, 32'h1);
         wait_end(n, st);
         chk("tbl_lat", n, vt[i].lat);
         chk("tbl_done_err", {done, err}, vt[i].ok ? 32'h2 : 32'h1);
         chk("tbl_exit_state", {func, current_state, busy}, 0);
         chk("tbl_ops_held", st, 1);
         tick();
         chk("tbl_pulse_end", {done, err}, 0);
      end

      // add walks the FSM through 00011 and 00100; the terminal state never appears.
      send(10'b0011_001_010);
      chk("add_cs0", current_state, 0);
      tick();
      chk("add_cs1", {current_state, done}, {5'd3, 1'b0});
      tick();
      chk("add_cs2", {current_state, done}, {5'd4, 1'b0});
      tick();
      chk("add_done", {done, err, current_state, func, busy}, {2'b10, 5'd0, 4'd0, 1'b0});
      tick();
      chk("add_after", {done, func}, 0);

      // Watchdog: the FSM never reaches a terminal state.
      stub_loop = 1'b1;
      send(10'b0011_000_000);
      wait_end(n, st);
      chk("wd_lat", n, 8);
      chk("wd_err", {done, err, current_state, busy}, {2'b01, 5'd0, 1'b0});
      stub_loop = 1'b0;
      tick();

      // Reset in the middle of an add aborts it with no pulse.
      send(10'b0011_001_010);
      tick();
      chk("mid_cs", current_state, 5'd3);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_out", {func, input1, input2, current_state, busy, done, err}, 0);
      tick();
      chk("mid_rst_pulse", {done, err}, 0);
      resetn = 1'b1;
      tick();
      chk("mid_rst_ready", {bus.instr_ready, done, err}, 3'b100);

      // Back-to-back sub then xor with valid held.
      send(10'b0100_001_010);
      bus.instr = 10'b0101_011_100;
      bus.instr_valid = 1'b1;
`ifdef SEQ_PREFETCH_EN
      tick();
      bus.instr_valid = 1'b0;
      tick();
      tick();
      chk("b2b_xor_start", {done, func, current_state, busy}, {1'b1, 4'b0101, 5'd0, 1'b1});
`else
      tick();
      tick();
      tick();
      chk("b2b_sub_done", {done, func, bus.instr_ready}, {1'b1, 4'd0, 1'b0});
      tick();
      chk("b2b_bubble", {done, busy, func, bus.instr_ready}, {1'b0, 1'b0, 4'd0, 1'b1});
      tick();
      bus.instr_valid = 1'b0;
      chk("b2b_xor_start", {func, current_state, busy}, {4'b0101, 5'd0, 1'b1});
`endif
      wait_end(n, st);
      chk("b2b_xor_done", {n[3:0], done, input1, input2}, {4'd3, 1'b1, 3'b011, 3'b100});
      tick();

      // Random instructions against the outcome model.
      for (int k = 0; k < 40; k++) begin
         logic [3:0] f;
         logic [2:0] rx, ry;
         logic       legal;
         logic [2:0] lat;
         logic [10:0] exp_w;
         f  = 4'($urandom_range(0, 15));
         rx = 3'($urandom_range(0, 7));
         ry = 3'($urandom_range(0, 7));
         legal = (f >= 4'd1) && (f <= 4'd9);
         lat = (legal && f >= 4'd3) ? 3'd3 : 3'd1;
         exp_q.push_back({legal, !legal, lat, rx, ry});
         repeat ($urandom_range(0, 2)) tick();
         send({f, rx, ry});
         wait_end(n, st);
         exp_w = exp_q.pop_front();
         chk("rnd_result", {done, err, n[2:0], input1, input2}, 32'(exp_w));
         chk("rnd_ops_held", st, 1);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
